serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_pkg.sv | 10 +
 rtl/full_adder.sv | 17 +
 rtl/serial_adder.sv | 94 +++++++++
 tb/tb_serial_adder.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared encodings for the bit-serial adder/subtractor.
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Generic ripple full adder. The serial datapath uses it at WIDTH = 1.
module full_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  // Widen by one bit so the carry falls out of the top of the sum.
  always_comb begin
    {cout, s} = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract, LSB first, one bit per clock, one op in flight.
// Subtraction is A + ~B + 1, so cout reads as "no borrow" (A >= B).
module serial_adder
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa, opb, res;
  logic             carry, cout_r, zero_r;
  logic             fa_s, fa_c;
  logic [WIDTH-1:0] res_nxt;

  full_adder #(.WIDTH(1)) u_fa (
    .a    (opa[0]),
    .b    (opb[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign res_nxt = {fa_s, res[WIDTH-1:1]};

  // Handshake flags are pure decodes of the state register.
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign sum       = res;
  assign cout      = cout_r;
  assign zero      = zero_r;

  // Control FSM and serial datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      opa    <= '0;
      opb    <= '0;
      res    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      zero_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          res   <= res_nxt;
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          carry <= fa_c;
          if (cnt == LAST) begin
            cout_r <= fa_c;
            zero_r <= (res_nxt == '0);
            state  <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          // Result registers are untouched here, so they hold under backpressure.
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases plus random ops
// checked against an arithmetic reference model.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] a, b;
  logic             sub;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout, zero;

  int n_chk  = 0;
  int n_fail = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the captured operands.
  task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input logic ms,
                       output logic [WIDTH-1:0] es, output logic ec, output logic ez);
    int unsigned r;
    if (ms) begin
      r  = (int'(ma) - int'(mb)) & ((1 << WIDTH) - 1);
      ec = (ma >= mb);
    end else begin
      r  = int'(ma) + int'(mb);
      ec = (r >= (1 << WIDTH));
    end
    es = WIDTH'(r);
    ez = (es == '0);
  endtask

  // One full transaction. bp = cycles of out_ready low in DONE (in_valid held
  // high meanwhile), scr = scramble inputs during SHIFT.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic ts,
                        input int bp, input bit scr);
    logic [WIDTH-1:0] es;
    logic ec, ez;
    logic [WIDTH-1:0] s0;
    logic c0, z0;
    int cyc;
    model(ta, tb_, ts, es, ec, ez);
    @(negedge clk);
    chk("ready_before_accept", in_ready, 1'b1);
    a = ta; b = tb_; sub = ts; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      if (out_valid || cyc > 4 * WIDTH) break;
      if (in_ready) chk("in_ready_in_shift", in_ready, 1'b0);
      if (scr) begin
        a = WIDTH'($urandom); b = WIDTH'($urandom); sub = 1'($urandom);
        in_valid = 1'($urandom);
      end
      @(posedge clk);
      cyc++;
    end
    chk("latency", 64'(cyc), 64'(WIDTH));
    chk("sum", sum, es);
    chk("cout", cout, ec);
    chk("zero", zero, ez);
    s0 = sum; c0 = cout; z0 = zero;
    for (int i = 0; i < bp; i++) begin
      in_valid = 1'b1;
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      @(negedge clk);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_sum_hold", sum, s0);
      chk("bp_flags_hold", {cout, zero}, {c0, z0});
    end
    out_ready = 1'b1;
    @(negedge clk);
    // in_valid may still be high here: the handshake edge must not also accept.
    chk("post_hs_valid", out_valid, 1'b0);
    chk("post_hs_ready", in_ready, 1'b1);
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, '0);
    chk("rst_flags", {cout, zero}, 2'b00);

    run_op(8'h3C, 8'h0F, 1'b0, 0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    run_op(8'h05, 8'h07, 1'b1, 0, 1'b0);
    run_op(8'h07, 8'h07, 1'b1, 0, 1'b0);
    run_op(8'h5A, 8'h33, 1'b0, 5, 1'b0);

    // Abort mid-SHIFT: rst sampled on the 4th SHIFT edge.
    @(negedge clk);
    a = 8'hAA; b = 8'h55; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_sum", sum, '0);
    run_op(8'h10, 8'h20, 1'b0, 0, 1'b0);

    run_op(8'h00, 8'h01, 1'b1, 0, 1'b1);
    run_op(8'h80, 8'h80, 1'b0, 1, 1'b1);
    for (int i = 0; i < 40; i++)
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
